// File: rtl/gabor_window_5x5_gen_pkg.sv
// gabor_win_pkg: shared constants and types for the 5x5 window generator.
// Window taps are numbered row-major from the top-left corner.
package gabor_win_pkg;

  localparam int WIN_DIM  = 5;
  localparam int WIN_TAPS = 25;
  localparam int PIXEL_W  = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } win_state_e;

  function automatic int tap_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

endpackage

// File: rtl/gabor_window_5x5_gen_line_buffer.sv
// gabor_line_buffer: one image line of pixels.
// Read is asynchronous, write is synchronous; contents are never reset.
module gabor_line_buffer #(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(IMG_W)-1:0]   addr,
  input  logic [PIXEL_W-1:0]         wdata,
  output logic [PIXEL_W-1:0]         rdata
);

  logic [PIXEL_W-1:0] mem [IMG_W];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/gabor_window_5x5_gen.sv
// gabor_window_5x5_gen: 5x5 sliding window over a raster pixel stream.
// Define GABOR_WIN_FRAME_MARKERS_EN to add the win_sof/win_eol outputs.
module gabor_window_5x5_gen #(
  parameter int PIXEL_W = gabor_win_pkg::PIXEL_W,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIXEL_W-1:0]   in_pixel,
  input  logic                 in_sof,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [25*PIXEL_W-1:0] win_pixel
`ifdef GABOR_WIN_FRAME_MARKERS_EN
  ,
  output logic                 win_sof,
  output logic                 win_eol
`endif
);
  import gabor_win_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRE = CW'(WIN_DIM - 1);
  localparam logic [RW-1:0] ROW_FIRE = RW'(WIN_DIM - 1);

  logic          accept;
  logic          xfer;
  logic          fire;
  logic          last_col;
  logic          wrap;
  logic [CW-1:0] col_q;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] row_q;
  logic [RW-1:0] cur_row;

  logic [PIXEL_W-1:0] lb_wr [4];
  logic [PIXEL_W-1:0] lb_rd [4];
  logic [PIXEL_W-1:0] col_new [WIN_DIM];
  logic [PIXEL_W-1:0] win_q [WIN_DIM][WIN_DIM];

  win_state_e state_q;
  win_state_e state_d;

  assign in_ready = rst_n & (~win_valid | win_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = win_valid & win_ready;

  // sof overrides the counters so a new frame can start anywhere
  assign cur_col  = in_sof ? '0 : col_q;
  assign cur_row  = in_sof ? '0 : row_q;
  assign last_col = (cur_col == COL_LAST);
  assign wrap     = last_col && (cur_row == ROW_LAST);
  assign fire     = (cur_row >= ROW_FIRE) && (cur_col >= COL_FIRE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  assign lb_wr[0] = in_pixel;
  assign lb_wr[1] = lb_rd[0];
  assign lb_wr[2] = lb_rd[1];
  assign lb_wr[3] = lb_rd[2];

  for (genvar i = 0; i < 4; i++) begin : g_lb
    gabor_line_buffer #(
      .PIXEL_W(PIXEL_W),
      .IMG_W  (IMG_W)
    ) u_lb (
      .clk  (clk),
      .we   (accept),
      .addr (cur_col),
      .wdata(lb_wr[i]),
      .rdata(lb_rd[i])
    );
  end

  // oldest line lands in the top window row
  assign col_new[0] = lb_rd[3];
  assign col_new[1] = lb_rd[2];
  assign col_new[2] = lb_rd[1];
  assign col_new[3] = lb_rd[0];
  assign col_new[4] = in_pixel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][WIN_DIM-1] <= col_new[r];
      end
    end
  end

  always_comb begin
    win_pixel = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        win_pixel[tap_idx(r, c)*PIXEL_W +: PIXEL_W] = win_q[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
    end else if (accept && fire) begin
      win_valid <= 1'b1;
    end else if (xfer) begin
      win_valid <= 1'b0;
    end
  end

`ifdef GABOR_WIN_FRAME_MARKERS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_sof <= 1'b0;
      win_eol <= 1'b0;
    end else if (accept) begin
      win_sof <= fire && (cur_row == ROW_FIRE) && (cur_col == COL_FIRE);
      win_eol <= fire && last_col;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (IMG_H == WIN_DIM && cur_row == ROW_FIRE) ? RUN : FILL;
        end
      end
      FILL: begin
        if (accept && cur_row == ROW_FIRE) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && (wrap || in_sof)) begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gabor_window_5x5_gen.sv
// tb_gabor_window_5x5_gen: frame-array reference model plus directed tables.
// Build with GABOR_WIN_FRAME_MARKERS_EN to also check win_sof/win_eol.
module tb_gabor_window_5x5_gen;

  localparam int PW = 8;
  localparam int IW = 8;
  localparam int IH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic win_ready = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic in_ready;
  logic win_valid;
  logic [25*PW-1:0] win_pixel;
`ifdef GABOR_WIN_FRAME_MARKERS_EN
  logic win_sof;
  logic win_eol;
`endif

  gabor_window_5x5_gen #(
    .PIXEL_W(PW),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pixel (in_pixel),
    .in_sof   (in_sof),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_pixel(win_pixel)
`ifdef GABOR_WIN_FRAME_MARKERS_EN
    ,
    .win_sof  (win_sof),
    .win_eol  (win_eol)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         win;
    int         tap;
    logic [7:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0]   frame [IH][IW];
  int           mr = 0;
  int           mc = 0;
  logic         exp_wv = 1'b0;
  logic [199:0] exp_win = '0;
  logic         exp_sof = 1'b0;
  logic         exp_eol = 1'b0;
  logic         last_acc = 1'b0;
  int           n_xfer = 0;
  logic [199:0] capt [$];
  int           sof_cnt = 0;
  bit           sof_watch = 1'b0;

  task automatic chk(input string name, input logic [199:0] act,
                     input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ramp(input int idx);
    return 8'((idx / IW) * 16 + (idx % IW));
  endfunction

  function automatic logic [7:0] tap_of(input logic [199:0] w, input int k);
    return w[(k-1)*8 +: 8];
  endfunction

  // window is read straight out of the remembered frame image
  task automatic model_accept(input logic [7:0] px, input logic s,
                              input logic xf);
    int r;
    int c;
    r = s ? 0 : mr;
    c = s ? 0 : mc;
    frame[r][c] = px;
    if (r >= 4 && c >= 4) begin
      exp_wv = 1'b1;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          exp_win[(i*5+j)*8 +: 8] = frame[r-4+i][c-4+j];
        end
      end
      exp_sof = (r == 4 && c == 4);
      exp_eol = (c == IW - 1);
    end else if (xf) begin
      exp_wv = 1'b0;
    end
    c++;
    if (c == IW) begin
      c = 0;
      r = (r == IH - 1) ? 0 : r + 1;
    end
    mr = r;
    mc = c;
  endtask

  task automatic cycle(input logic v, input logic [7:0] px, input logic s,
                       input logic rdy);
    logic exp_rdy;
    logic xf;
    in_valid  = v;
    in_pixel  = px;
    in_sof    = s;
    win_ready = rdy;
    @(negedge clk);
    exp_rdy = rst_n & (~exp_wv | rdy);
    chk("in_ready", {199'd0, in_ready}, {199'd0, exp_rdy});
    chk("win_valid", {199'd0, win_valid}, {199'd0, exp_wv});
    if (exp_wv) begin
      chk("win_pixel", win_pixel, exp_win);
`ifdef GABOR_WIN_FRAME_MARKERS_EN
      chk("win_sof", {199'd0, win_sof}, {199'd0, exp_sof});
      chk("win_eol", {199'd0, win_eol}, {199'd0, exp_eol});
`endif
    end
    if (sof_watch && win_valid) begin
      chk("sof_gap", 200'(sof_cnt), 200'd36);
      sof_watch = 1'b0;
    end
    if (win_valid && rdy) begin
      n_xfer++;
      capt.push_back(win_pixel);
    end
    xf = exp_wv & rdy;
    last_acc = v & exp_rdy;
    if (!rst_n) begin
      exp_wv = 1'b0;
      mr = 0;
      mc = 0;
    end else if (last_acc) begin
      if (sof_watch) sof_cnt++;
      model_accept(px, s, xf);
    end else if (xf) begin
      exp_wv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] px, input logic s, input bit rnd);
    int tries;
    logic v;
    logic r;
    tries = 0;
    do begin
      v = rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1;
      r = rnd ? logic'($urandom_range(0, 2) != 0) : 1'b1;
      cycle(v, px, s, r);
      tries++;
    end while (!last_acc && tries < 200);
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout act=no_accept exp=accept px=%h", px);
    end
  endtask

  task automatic send_range(input int first, input int last, input bit sof0,
                            input bit rnd);
    for (int i = first; i <= last; i++) begin
      push(ramp(i), sof0 && (i == first), rnd);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic chk_tap(input string name, input int win, input int k,
                         input logic [7:0] exp);
    if (capt.size() > win) begin
      chk(name, {192'd0, tap_of(capt[win], k)}, {192'd0, exp});
    end else begin
      checks++;
      errors++;
      $display("FAIL %s act=missing_window exp=%h", name, exp);
    end
  endtask

  initial begin
    vec_t tbl [8];
    logic [199:0] hold;

    tbl[0] = '{0, 1, 8'h00};
    tbl[1] = '{0, 13, 8'h22};
    tbl[2] = '{0, 25, 8'h44};
    tbl[3] = '{1, 25, 8'h45};
    tbl[4] = '{3, 25, 8'h47};
    tbl[5] = '{4, 1, 8'h10};
    tbl[6] = '{7, 1, 8'h13};
    tbl[7] = '{7, 25, 8'h57};

    repeat (2) @(posedge clk);
    #1;
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    chk("rst_win_pixel", win_pixel, '0);
    chk("rst_win_valid", {199'd0, win_valid}, '0);
    rst_n = 1'b1;

    capt.delete();
    n_xfer = 0;
    send_range(0, IW * IH - 1, 1'b1, 1'b0);
    drain();
    chk("ramp_count", 200'(n_xfer), 200'd8);
    for (int i = 0; i < 8; i++) begin
      chk_tap($sformatf("ramp_w%0d_t%0d", tbl[i].win, tbl[i].tap),
              tbl[i].win, tbl[i].tap, tbl[i].exp);
    end

    capt.delete();
    n_xfer = 0;
    send_range(0, 36, 1'b1, 1'b0);
    hold = win_pixel;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, ramp(37), 1'b0, 1'b0);
      chk("stall_hold", win_pixel, hold);
      chk("stall_valid", {199'd0, win_valid}, 200'd1);
    end
    send_range(37, IW * IH - 1, 1'b0, 1'b0);
    drain();
    chk("bp_count", 200'(n_xfer), 200'd8);
    chk_tap("bp_first", 0, 25, 8'h44);
    chk_tap("bp_next", 1, 25, 8'h45);

    capt.delete();
    n_xfer = 0;
    send_range(0, 18, 1'b1, 1'b0);
    push(8'h00, 1'b1, 1'b0);
    sof_cnt = 0;
    sof_watch = 1'b1;
    send_range(1, IW * IH - 1, 1'b0, 1'b0);
    drain();
    chk("sof_watch_done", {199'd0, sof_watch}, '0);
    chk("sof_count", 200'(n_xfer), 200'd8);
    chk_tap("sof_t1", 0, 1, 8'h00);
    chk_tap("sof_t25", 0, 25, 8'h44);

    send_range(0, 40, 1'b1, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("mid_rst_valid", {199'd0, win_valid}, '0);
    capt.delete();
    n_xfer = 0;
    send_range(0, IW * IH - 1, 1'b0, 1'b0);
    drain();
    chk("rst_count", 200'(n_xfer), 200'd8);
    chk_tap("rst_t13", 0, 13, 8'h22);
    chk_tap("rst_t25", 0, 25, 8'h44);

    n_xfer = 0;
    for (int f = 0; f < 3; f++) begin
      send_range(0, IW * IH - 1, 1'b1, 1'b1);
    end
    drain();
    chk("rand_count", 200'(n_xfer), 200'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
